// File: rtl/some_type_if.sv
// Valid/ready bundle between the go-source, the list kernel and the list consumer.
// The kernel attaches as slave; the environment attaches as master.
interface some_type_if #(
  parameter int DATA_W = 8
);
  logic              sourceGo_d;
  logic              sourceGo_r;
  logic [DATA_W+1:0] sink_d;
  logic              sink_r;

  modport master (
    output sourceGo_d,
    input  sourceGo_r,
    input  sink_d,
    output sink_r
  );

  modport slave (
    input  sourceGo_d,
    output sourceGo_r,
    output sink_d,
    input  sink_r
  );
endinterface

// File: rtl/some_type.sv
// List generator: each accepted Go token yields Cons(0) .. Cons(LEN-1) followed by Nil.
// All outputs come straight from flops; sink_d is {valid, tag, element}.
module some_type #(
  parameter int DATA_W = 8,
  parameter int LEN    = 4
) (
  input  logic        clk,
  input  logic        reset,
  some_type_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    NIL
  } state_t;

  localparam int                LAST_I = (LEN > 0) ? LEN - 1 : 0;
  localparam logic [DATA_W-1:0] LAST   = DATA_W'(LAST_I);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] counter_q, counter_d;
  logic              go_ready_q, go_ready_d;
  logic [DATA_W+1:0] tok_q, tok_d;
  logic              go_xfer;
  logic              sink_xfer;

  assign go_xfer   = bus.sourceGo_d & go_ready_q;
  assign sink_xfer = tok_q[DATA_W+1] & bus.sink_r;

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    go_ready_d = go_ready_q;
    tok_d      = tok_q;
    unique case (state_q)
      IDLE: begin
        go_ready_d = 1'b1;
        tok_d      = '0;
        if (go_xfer) begin
          go_ready_d = 1'b0;
          counter_d  = '0;
          if (LEN > 0) begin
            state_d = EMIT;
            tok_d   = {2'b11, {DATA_W{1'b0}}};
          end else begin
            state_d = NIL;
            tok_d   = {2'b10, {DATA_W{1'b0}}};
          end
        end
      end
      EMIT: begin
        go_ready_d = 1'b0;
        // The next element is loaded on the same edge that consumes the current one, so no bubble.
        if (sink_xfer) begin
          if (counter_q != LAST) begin
            counter_d = counter_q + 1'b1;
            tok_d     = {2'b11, counter_d};
          end else begin
            state_d = NIL;
            tok_d   = {2'b10, {DATA_W{1'b0}}};
          end
        end
      end
      NIL: begin
        go_ready_d = 1'b0;
        if (sink_xfer) begin
          state_d    = IDLE;
          go_ready_d = 1'b1;
          tok_d      = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        go_ready_d = 1'b0;
        tok_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      go_ready_q <= 1'b0;
      tok_q      <= '0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      go_ready_q <= go_ready_d;
      tok_q      <= tok_d;
    end
  end

  assign bus.sourceGo_r = go_ready_q;
  assign bus.sink_d     = tok_q;

endmodule

// File: tb/tb_some_type.sv
// Bench for some_type: three instances (LEN=4, LEN=0, DATA_W=2) checked every cycle against
// a list-level model where each accepted Go enqueues the whole expected list of tokens.
module tb_some_type;

  logic       clk;
  logic       reset;
  logic [2:0] go_v;
  logic [2:0] snk_r;

  some_type_if #(.DATA_W(8)) bus0 ();
  some_type_if #(.DATA_W(8)) bus1 ();
  some_type_if #(.DATA_W(2)) bus2 ();

  assign bus0.sourceGo_d = go_v[0];
  assign bus1.sourceGo_d = go_v[1];
  assign bus2.sourceGo_d = go_v[2];
  assign bus0.sink_r     = snk_r[0];
  assign bus1.sink_r     = snk_r[1];
  assign bus2.sink_r     = snk_r[2];

  some_type #(.DATA_W(8), .LEN(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  some_type #(.DATA_W(8), .LEN(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  some_type #(.DATA_W(2), .LEN(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int          n_checks;
  int          n_fail;
  int          expq[3][$];
  int          gos[3];
  int          gos_before[3];
  logic        obs_v[3];
  logic        obs_tag[3];
  logic [31:0] obs_dat[3];
  logic        obs_gor[3];
  logic        found;
  logic [3:0]  pat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  function automatic int len_of(input int id);
    case (id)
      0:       return 4;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sample();
    obs_v[0]   = bus0.sink_d[9];
    obs_tag[0] = bus0.sink_d[8];
    obs_dat[0] = {24'b0, bus0.sink_d[7:0]};
    obs_gor[0] = bus0.sourceGo_r;
    obs_v[1]   = bus1.sink_d[9];
    obs_tag[1] = bus1.sink_d[8];
    obs_dat[1] = {24'b0, bus1.sink_d[7:0]};
    obs_gor[1] = bus1.sourceGo_r;
    obs_v[2]   = bus2.sink_d[3];
    obs_tag[2] = bus2.sink_d[2];
    obs_dat[2] = {30'b0, bus2.sink_d[1:0]};
    obs_gor[2] = bus2.sourceGo_r;
  endtask

  task automatic clear_model();
    for (int id = 0; id < 3; id++) expq[id].delete();
  endtask

  task automatic check_reset(input string tag);
    check_output({tag, " dut0 sink_d"}, {22'b0, bus0.sink_d}, 32'd0);
    check_output({tag, " dut1 sink_d"}, {22'b0, bus1.sink_d}, 32'd0);
    check_output({tag, " dut2 sink_d"}, {28'b0, bus2.sink_d}, 32'd0);
    check_output({tag, " dut0 go_r"}, {31'b0, bus0.sourceGo_r}, 32'd0);
    check_output({tag, " dut1 go_r"}, {31'b0, bus1.sourceGo_r}, 32'd0);
    check_output({tag, " dut2 go_r"}, {31'b0, bus2.sourceGo_r}, 32'd0);
  endtask

  // One clock: decide which transfers happened from the values seen before the edge, then compare.
  task automatic apply_stimulus();
    logic p_v[3];
    logic p_gor[3];
    logic [2:0] in_go;
    logic [2:0] in_r;
    int exp_tok;
    for (int id = 0; id < 3; id++) begin
      p_v[id]   = obs_v[id];
      p_gor[id] = obs_gor[id];
    end
    in_go = go_v;
    in_r  = snk_r;
    @(posedge clk);
    #1;
    sample();
    for (int id = 0; id < 3; id++) begin
      if (p_gor[id] && in_go[id]) begin
        gos[id]++;
        for (int k = 0; k < len_of(id); k++) expq[id].push_back(k);
        expq[id].push_back(-1);
      end
      if (p_v[id] && in_r[id] && expq[id].size() > 0) void'(expq[id].pop_front());
      check_output($sformatf("dut%0d go_ready", id), {31'b0, obs_gor[id]},
                   {31'b0, expq[id].size() == 0});
      check_output($sformatf("dut%0d sink valid", id), {31'b0, obs_v[id]},
                   {31'b0, expq[id].size() != 0});
      if (expq[id].size() > 0) begin
        exp_tok = expq[id][0];
        check_output($sformatf("dut%0d sink tag", id), {31'b0, obs_tag[id]},
                     {31'b0, exp_tok >= 0});
        check_output($sformatf("dut%0d sink data", id), obs_dat[id],
                     (exp_tok >= 0) ? 32'(exp_tok) : 32'd0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int id = 0; id < 3; id++) gos[id] = 0;
    reset = 1'b1;
    go_v  = '0;
    snk_r = '1;

    #2;
    check_reset("reset");
    @(posedge clk);
    #1;
    check_reset("reset held");
    #3 reset = 1'b0;
    sample();
    clear_model();

    // Single Go, consumer always ready.
    go_v = '1;
    apply_stimulus();
    apply_stimulus();
    go_v = '0;
    for (int i = 0; i < 7; i++) apply_stimulus();
    check_output("dut0 single go count", 32'(gos[0]), 32'd1);
    check_output("dut1 single go count", 32'(gos[1]), 32'd1);
    check_output("dut2 single go count", 32'(gos[2]), 32'd1);

    // Single Go, consumer ready pattern 1,0,0,1 repeating.
    pat = 4'b1001;
    go_v = '1;
    for (int i = 0; i < 16; i++) begin
      snk_r = {3{pat[i % 4]}};
      apply_stimulus();
      go_v = '0;
    end
    snk_r = '1;
    for (int i = 0; i < 8; i++) apply_stimulus();

    // Go held permanently: one list every LEN+2 cycles.
    for (int id = 0; id < 3; id++) gos_before[id] = gos[id];
    go_v = '1;
    for (int i = 0; i < 30; i++) apply_stimulus();
    go_v = '0;
    check_output("dut0 held go count", 32'(gos[0] - gos_before[0]), 32'd5);
    check_output("dut1 held go count", 32'(gos[1] - gos_before[1]), 32'd15);
    check_output("dut2 held go count", 32'(gos[2] - gos_before[2]), 32'd5);
    for (int i = 0; i < 8; i++) apply_stimulus();

    // Asynchronous reset in the middle of a list.
    go_v = '1;
    apply_stimulus();
    go_v = '0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      apply_stimulus();
      if (obs_v[0] && obs_dat[0] == 32'd1) found = 1'b1;
    end
    check_output("wait for cons1", {31'b0, found}, 32'd1);
    apply_stimulus();
    #2 reset = 1'b1;
    #1;
    check_reset("async abort");
    @(posedge clk);
    #1;
    check_reset("abort held");
    #3 reset = 1'b0;
    sample();
    clear_model();
    go_v = '1;
    apply_stimulus();
    apply_stimulus();
    go_v = '0;
    check_output("restart valid", {31'b0, obs_v[0]}, 32'd1);
    check_output("restart tag", {31'b0, obs_tag[0]}, 32'd1);
    check_output("restart data", obs_dat[0], 32'd0);
    for (int i = 0; i < 8; i++) apply_stimulus();

    // Random Go and consumer readiness on every instance.
    for (int i = 0; i < 300; i++) begin
      go_v  = 3'($urandom_range(0, 7));
      snk_r = 3'($urandom_range(0, 7));
      apply_stimulus();
    end
    go_v  = '0;
    snk_r = '1;
    for (int i = 0; i < 10; i++) apply_stimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
